token_precision_quantizer: RTL and testbench

Consumer of the per-token precision codes produced by the precision analyzer: streams L tokens of D signed 16-bit elements (Q8.8) and re-encodes each element to INT4, INT8 or FP16-passthrough according to its token's 4-bit code. It sits between the attention/value datapath and the mixed-precision compute units. It emits a valid/ready stream of sign-extended quantized values tagged with their code.

---
 rtl/token_precision_quantizer.sv | 153 +++++++++++++++
 tb/tb_token_precision_quantizer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/token_precision_quantizer.sv
// Re-encodes a token-major stream of Q8.8 elements to INT4 / INT8 / FP16 per token code.
// Optional rounding and saturation enabled by defining TPQ_ROUND_EN.
module token_precision_quantizer #(
    parameter int DATA_WIDTH = 16,
    parameter int L = 8,
    parameter int D = 4,
    localparam int TW = (L > 1) ? $clog2(L) : 1,
    localparam int EW = (D > 1) ? $clog2(D) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            token_precision [0:L-1],
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_code,
    output logic [TW-1:0]         out_token,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fsm_state
);

    // Handshakes: a beat transfers on a rising edge where valid && ready; valid
    // is never withdrawn and data is held stable until that edge.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [TW-1:0] TOK_MAX  = TW'(L - 1);
    localparam logic [EW-1:0] ELEM_MAX = EW'(D - 1);

    state_t          state_q, state_d;
    logic [3:0]      codes_q [0:L-1];
    logic [TW-1:0]   tok_cnt;
    logic [EW-1:0]   elem_cnt;
    logic            in_hs;
    logic            last_elem;
    logic [3:0]      eff_code;
    logic [DATA_WIDTH-1:0] q4, q8, result;

    assign in_hs     = in_valid && in_ready;
    assign last_elem = (tok_cnt == TOK_MAX) && (elem_cnt == ELEM_MAX);
    assign eff_code  = (codes_q[tok_cnt] > 4'd2) ? 4'd2 : codes_q[tok_cnt];
    assign fsm_state = state_q;

`ifdef TPQ_ROUND_EN
    localparam logic signed [DATA_WIDTH:0] RND8    = 128;
    localparam logic signed [DATA_WIDTH:0] RND4    = 2048;
    localparam logic signed [DATA_WIDTH:0] SAT8_HI = 127;
    localparam logic signed [DATA_WIDTH:0] SAT8_LO = -128;
    localparam logic signed [DATA_WIDTH:0] SAT4_HI = 7;
    localparam logic signed [DATA_WIDTH:0] SAT4_LO = -8;

    logic signed [DATA_WIDTH:0] xe, r8, r4;

    // One extra bit keeps x + bias from wrapping near +full-scale.
    always_comb begin
        xe = {in_data[DATA_WIDTH-1], in_data};
        r8 = (xe + RND8) >>> 8;
        r4 = (xe + RND4) >>> 12;
        if (r8 > SAT8_HI)      q8 = DATA_WIDTH'(127);
        else if (r8 < SAT8_LO) q8 = {{(DATA_WIDTH-8){1'b1}}, 8'h80};
        else                   q8 = r8[DATA_WIDTH-1:0];
        if (r4 > SAT4_HI)      q4 = DATA_WIDTH'(7);
        else if (r4 < SAT4_LO) q4 = {{(DATA_WIDTH-4){1'b1}}, 4'h8};
        else                   q4 = r4[DATA_WIDTH-1:0];
    end
`else
    logic signed [DATA_WIDTH-1:0] xs;

    always_comb begin
        xs = in_data;
        q8 = xs >>> 8;
        q4 = xs >>> 12;
    end
`endif

    always_comb begin
        case (eff_code)
            4'd0:    result = q4;
            4'd1:    result = q8;
            default: result = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                busy     = 1'b1;
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && last_elem) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            codes_q   <= '{default: '0};
            tok_cnt   <= '0;
            elem_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_code  <= '0;
            out_token <= '0;
            out_last  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                codes_q  <= token_precision;
                tok_cnt  <= '0;
                elem_cnt <= '0;
            end
            // A fresh beat may overwrite the stage in the same cycle it drains.
            if (in_hs) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_code  <= eff_code;
                out_token <= tok_cnt;
                out_last  <= last_elem;
                if (elem_cnt == ELEM_MAX) begin
                    elem_cnt <= '0;
                    tok_cnt  <= (tok_cnt == TOK_MAX) ? '0 : tok_cnt + 1'b1;
                end else begin
                    elem_cnt <= elem_cnt + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_token_precision_quantizer.sv
// Directed bench for token_precision_quantizer: vector table frame, stalled frame,
// mid-frame reset and a clean follow-up frame. Handles both TPQ_ROUND_EN builds.
module tb_token_precision_quantizer;

    localparam int L = 8;
    localparam int D = 4;
    localparam int N = L * D;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
    logic [3:0]  token_precision [0:L-1];
    logic [15:0] in_data, out_data;
    logic [3:0]  out_code;
    logic [2:0]  out_token;
    logic [1:0]  fsm_state, idle_state;

    token_precision_quantizer #(.DATA_WIDTH(16), .L(L), .D(D)) dut (
        .clk(clk), .rst(rst), .start(start), .token_precision(token_precision),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_code(out_code), .out_token(out_token), .out_last(out_last),
        .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] x;
        logic [15:0] exp_rnd;
        logic [15:0] exp_trc;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t        vecs [0:L-1];
    logic [23:0] exp_q [$];
    logic [3:0]  frame_codes [0:L-1];
    logic [3:0]  frame_ecode [0:L-1];
    logic [15:0] frame_x     [0:N-1];
    logic [15:0] frame_exp   [0:N-1];
    logic [15:0] xlist       [0:7];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] code, input logic [15:0] x);
        int v, q;
        v = $signed(x);
        if (code == 4'd0) begin
`ifdef TPQ_ROUND_EN
            q = (v + 2048) >>> 12;
            if (q > 7) q = 7;
            if (q < -8) q = -8;
`else
            q = v >>> 12;
`endif
        end else if (code == 4'd1) begin
`ifdef TPQ_ROUND_EN
            q = (v + 128) >>> 8;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
`else
            q = v >>> 8;
`endif
        end else begin
            q = v;
        end
        return q[15:0];
    endfunction

    task automatic run_frame(input int stall_at, input int stall_len, input int rst_after,
                             input int exp_done);
        int cyc, sent, recv, first_rdy, done_cyc, done_cnt;
        logic [23:0] got, prev;
        logic held;
        exp_q.delete();
        sent = 0; recv = 0; first_rdy = -1; done_cyc = -1; done_cnt = 0; held = 0; prev = '0;
        @(posedge clk); #1;
        token_precision = frame_codes;
        start = 1; in_valid = 1; in_data = frame_x[0]; out_ready = 1; cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            got = {out_last, out_token, out_code, out_data};
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (in_ready && first_rdy < 0) first_rdy = cyc;
            if (held) check("hold_out", {7'd0, out_valid, got}, {7'd0, 1'b1, prev});
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            held = out_valid && !out_ready;
            prev = got;
            if (in_valid && in_ready) begin
                exp_q.push_back({(sent == N - 1), 3'(sent / D), frame_ecode[sent / D], frame_exp[sent]});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_extra: got %0h expected no beat", got);
                end else begin
                    check($sformatf("out[%0d]", recv), 32'(got), 32'(exp_q.pop_front()));
                end
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
            start = 0;
            token_precision = '{default: 4'hF};
            if (done_cyc >= 0) break;
            if (rst_after >= 0 && sent == rst_after) break;
            in_valid  = (sent < N);
            in_data   = frame_x[(sent < N) ? sent : 0];
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
        end
        in_valid = 0;
        if (rst_after >= 0) begin
            rst = 1; out_ready = 1;
            @(posedge clk); #1;
            rst = 0;
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_fields", {8'd0, out_last, out_token, out_code, out_data}, 32'd0);
            check("rst_ctrl", {29'd0, in_ready, busy, done}, 32'd0);
            done_cnt = 0;
            repeat (6) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            check("rst_no_done", 32'(done_cnt), 32'd0);
            exp_q.delete();
        end else begin
            @(negedge clk);
            check("first_in_ready_cycle", 32'(first_rdy), 32'd1);
            check("done_cycle", 32'(done_cyc), 32'(exp_done));
            check("done_pulses", 32'(done_cnt + int'(done)), 32'd1);
            check("beats_out", 32'(recv), 32'(N));
            check("exp_q_empty", 32'(exp_q.size()), 32'd0);
            check("idle_after_done", {29'd0, busy, fsm_state}, {29'd0, 1'b0, idle_state});
        end
    endtask

    task automatic load_model_frame();
        frame_codes = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        for (int k = 0; k < L; k++) frame_ecode[k] = frame_codes[k];
        for (int i = 0; i < N; i++) begin
            frame_x[i]   = xlist[i % 8];
            frame_exp[i] = model(frame_codes[i / D], frame_x[i]);
        end
    endtask

    initial begin
        rst = 1; start = 0; in_valid = 0; in_data = '0; out_ready = 1;
        token_precision = '{default: 4'h0};
        vecs[0] = '{4'd1, 16'h1280, 16'h0013, 16'h0012, 4'd1};
        vecs[1] = '{4'd0, 16'h1800, 16'h0002, 16'h0001, 4'd0};
        vecs[2] = '{4'd1, 16'h7FFF, 16'h007F, 16'h007F, 4'd1};
        vecs[3] = '{4'd0, 16'h7FFF, 16'h0007, 16'h0007, 4'd0};
        vecs[4] = '{4'd1, 16'hFF80, 16'h0000, 16'hFFFF, 4'd1};
        vecs[5] = '{4'd2, 16'hABCD, 16'hABCD, 16'hABCD, 4'd2};
        vecs[6] = '{4'd7, 16'hABCD, 16'hABCD, 16'hABCD, 4'd2};
        vecs[7] = '{4'd0, 16'h8000, 16'hFFF8, 16'hFFF8, 4'd0};
        xlist = '{16'h1280, 16'h1800, 16'h7FFF, 16'hFF80, 16'h8000, 16'h0080, 16'hF7FF, 16'h0001};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        idle_state = fsm_state;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_fields", {8'd0, out_last, out_token, out_code, out_data}, 32'd0);
        check("reset_ctrl", {29'd0, in_ready, busy, done}, 32'd0);

        for (int k = 0; k < L; k++) begin
            frame_codes[k] = vecs[k].code;
            frame_ecode[k] = vecs[k].exp_code;
        end
        for (int i = 0; i < N; i++) begin
            frame_x[i] = vecs[i / D].x;
`ifdef TPQ_ROUND_EN
            frame_exp[i] = vecs[i / D].exp_rnd;
`else
            frame_exp[i] = vecs[i / D].exp_trc;
`endif
        end
        run_frame(1000, 0, -1, 34);

        load_model_frame();
        run_frame(10, 3, -1, 37);
        run_frame(1000, 0, 10, 0);
        run_frame(1000, 0, -1, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
